// File: rtl/fetch_stage_if.sv
// Instruction-memory bus between the fetch stage and an asynchronous ROM.
// The master drives the word address; the slave returns the word at that address in the same cycle.
interface fetch_stage_if;
  logic [15:0] imem_addr;
  logic [15:0] imem_rdata;

  modport master (output imem_addr, input  imem_rdata);
  modport slave  (input  imem_addr, output imem_rdata);
endinterface

// File: rtl/fetch_stage.sv
// Instruction fetch stage: word-addressed PC, IF/ID register, and a RUN/HALT state machine.
// Redirects from EX flush IF/ID; load-use stalls from ID freeze the stage.
module fetch_stage #(
  parameter logic [15:0] RESET_PC    = 16'h0000,
  parameter logic [3:0]  HALT_OPCODE = 4'hF,
  parameter logic [15:0] NOP_INST    = 16'h0000
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          stall,
  input  logic          redirect,
  input  logic [15:0]   redirect_pc,
  fetch_stage_if.master imem,
  output logic [15:0]   pc,
  output logic [15:0]   next_pc,
  output logic [15:0]   inst_id,
  output logic [15:0]   next_pc_id,
  output logic          valid_id,
  output logic          halted,
  output logic [15:0]   fetch_count
);

  typedef enum logic {RUN, HALT} state_t;

  state_t state;
  state_t state_nx;
  logic   is_halt;
  logic   advance;

  assign imem.imem_addr = pc;
  assign next_pc        = pc + 16'd1;
  assign is_halt        = (imem.imem_rdata[15:12] == HALT_OPCODE);
  assign advance        = (state == RUN) && !redirect && !stall;

  always_ff @(posedge clk) begin
    if (rst) state <= RUN;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (redirect)
      state_nx = RUN;
    else if (advance && is_halt)
      state_nx = HALT;
  end

  always_comb begin
    halted = (state == HALT);
  end

  // IF -> ID boundary
  always_ff @(posedge clk) begin
    if (rst) begin
      pc          <= RESET_PC;
      inst_id     <= NOP_INST;
      next_pc_id  <= 16'h0000;
      valid_id    <= 1'b0;
      fetch_count <= 16'h0000;
    end else if (redirect) begin
      pc       <= redirect_pc;
      inst_id  <= NOP_INST;
      valid_id <= 1'b0;
    end else if (state == HALT) begin
      inst_id  <= NOP_INST;
      valid_id <= 1'b0;
    end else if (!stall) begin
      // A halt word is still delivered, but the PC parks on it.
      pc          <= is_halt ? pc : next_pc;
      inst_id     <= imem.imem_rdata;
      next_pc_id  <= next_pc;
      valid_id    <= 1'b1;
      fetch_count <= fetch_count + 16'd1;
    end
  end

endmodule
